// File: rtl/mnist_pkg.sv
// Image geometry shared by the deserializer and the classifier layers.
package mnist_pkg;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int N_PIX = IMG_W * IMG_H;
  localparam int PIX_W = $clog2(N_PIX);
endpackage

// File: rtl/pixel_deserializer_if.sv
// Pixel stream in, assembled image out, with valid/ready on the image side.
interface pixel_deserializer_if;
  import mnist_pkg::*;

  logic             bit_in;
  logic             bit_valid;
  logic [N_PIX-1:0] img_data;
  logic             img_valid;
  logic             img_ready;

  modport master (
    output bit_in, bit_valid, img_ready,
    input  img_data, img_valid
  );

  modport slave (
    input  bit_in, bit_valid, img_ready,
    output img_data, img_valid
  );
endinterface

// File: rtl/image_bank.sv
// One image buffer: N_PIX flops, each with its own decoded write enable.
module image_bank
  import mnist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PIX_W-1:0] addr,
  input  logic             d,
  output logic [N_PIX-1:0] q
);

  // Only the addressed bit loads; all other bits hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < N_PIX; i++) begin
        if (we && (addr == PIX_W'(i))) q[i] <= d;
      end
    end
  end

endmodule

// File: rtl/pixel_deserializer.sv
// Serial-to-parallel image assembly into a ping-pong bank pair. A frame that
// starts while the next write bank is still full is discarded as a whole.
module pixel_deserializer
  import mnist_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_deserializer_if.slave  bus,
  output logic                 overrun,
  output logic [CNT_W-1:0]     img_count
);

  logic [PIX_W-1:0] pix_cnt;
  logic             wr_bank;
  logic             rd_bank;
  logic [1:0]       full;
  logic [1:0]       full_next;
  logic             drop;
  logic             drop_now;
  logic             frame_end;
  logic             accept;
  logic [1:0]       we;
  logic [N_PIX-1:0] bank_q [2];

  // At pixel 0 the drop decision is taken live so the first bit obeys it.
  assign drop_now  = (pix_cnt == '0) ? full[wr_bank] : drop;
  assign frame_end = bus.bit_valid && (pix_cnt == PIX_W'(N_PIX - 1));
  assign accept    = bus.img_valid && bus.img_ready;

  assign we[0] = bus.bit_valid && !drop_now && !wr_bank;
  assign we[1] = bus.bit_valid && !drop_now &&  wr_bank;

  assign bus.img_valid = full[rd_bank];
  assign bus.img_data  = rd_bank ? bank_q[1] : bank_q[0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    image_bank u_bank (
      .clk  (clk),
      .rst  (rst),
      .we   (we[b]),
      .addr (pix_cnt),
      .d    (bus.bit_in),
      .q    (bank_q[b])
    );
  end

  // Write-side control: pixel counter, frame drop, bank switch, counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt   <= '0;
      drop      <= 1'b0;
      wr_bank   <= 1'b0;
      overrun   <= 1'b0;
      img_count <= '0;
    end else if (bus.bit_valid) begin
      if (pix_cnt == '0) drop <= full[wr_bank];
      if (frame_end) begin
        pix_cnt <= '0;
        if (!drop_now) begin
          wr_bank   <= ~wr_bank;
          img_count <= img_count + 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  // Completion sets the write bank's flag and acceptance clears the read
  // bank's; both may happen in one cycle because they target different banks.
  always_comb begin
    full_next = full;
    if (accept) full_next[rd_bank] = 1'b0;
    if (frame_end && !drop_now) full_next[wr_bank] = 1'b1;
  end

  // Read-side state: bank full flags and the read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      rd_bank <= 1'b0;
    end else begin
      full <= full_next;
      if (accept) rd_bank <= ~rd_bank;
    end
  end

endmodule

// File: tb/tb_pixel_deserializer.sv
// Bench for pixel_deserializer: a queue-based reference model checked every
// cycle, a table of single-frame vectors, and directed corner-case sequences.
module tb_pixel_deserializer;
  import mnist_pkg::*;

  localparam int N = N_PIX;

  logic        clk;
  logic        rst;
  logic        overrun;
  logic [15:0] img_count;

  pixel_deserializer_if bus ();

  pixel_deserializer #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .overrun   (overrun),
    .img_count (img_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: held images in delivery order, frame being received.
  logic [N-1:0] m_held [$];
  logic [N-1:0] m_cur;
  int           m_pos;
  bit           m_drop;
  bit           m_ovr;
  logic [15:0]  m_cnt;

  logic [N-1:0] delivered [$];
  int           vcycles;
  int           consec;
  bit           prev_valid;

  function automatic void m_reset();
    m_held.delete();
    m_cur  = '0;
    m_pos  = 0;
    m_drop = 0;
    m_ovr  = 0;
    m_cnt  = '0;
  endfunction

  function automatic void m_step(bit bv, bit b, bit rdy);
    bit acc;
    acc = (m_held.size() != 0) && rdy;
    if (bv) begin
      if (m_pos == 0) m_drop = (m_held.size() == 2);
      m_cur[m_pos] = b;
      m_pos++;
      if (m_pos == N) begin
        m_pos = 0;
        if (m_drop) m_ovr = 1;
        else begin
          m_held.push_back(m_cur);
          m_cnt = m_cnt + 16'd1;
        end
      end
    end
    if (acc) void'(m_held.pop_front());
  endfunction

  function automatic logic [N-1:0] pattern(int kind);
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       p[i] = ~i[0];
        1:       p[i] = 1'b1;
        2:       p[i] = 1'b0;
        3:       p[i] = ((i % IMG_W) == (i / IMG_W));
        default: p[i] = ((i / IMG_W) % 2) == 1;
      endcase
    end
    return p;
  endfunction

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic check_vec(string name, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic cycle(bit bv, bit b, bit rdy);
    bus.bit_valid = bv;
    bus.bit_in    = b;
    bus.img_ready = rdy;
    if (bus.img_valid && rdy) delivered.push_back(bus.img_data);
    @(posedge clk);
    m_step(bv, b, rdy);
    #1;
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL cycle_budget got=%0d want<=90000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (bus.img_valid) begin
      vcycles++;
      if (prev_valid) consec++;
    end
    prev_valid = bus.img_valid;
    check_int("model_valid", int'(bus.img_valid), int'(m_held.size() != 0));
    if (m_held.size() != 0) check_vec("model_data", bus.img_data, m_held[0]);
    check_int("model_overrun", int'(overrun), int'(m_ovr));
    check_int("model_count", int'(img_count), int'(m_cnt));
  endtask

  task automatic idle(int n, bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, rdy);
  endtask

  // ready_from < 0: random ready; otherwise ready from that pixel index on.
  task automatic send_frame(logic [N-1:0] f, int vpct, int ready_from);
    int  i;
    bit  bv;
    bit  rdy;
    i = 0;
    while (i < N) begin
      bv  = ($urandom_range(0, 99) < vpct);
      rdy = (ready_from < 0) ? ($urandom_range(0, 3) == 0) : (i >= ready_from);
      cycle(bv, f[i], rdy);
      if (bv) i++;
    end
  endtask

  task automatic do_reset();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.img_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_int("rst_valid", int'(bus.img_valid), 0);
    check_vec("rst_data", bus.img_data, '0);
    check_int("rst_overrun", int'(overrun), 0);
    check_int("rst_count", int'(img_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    delivered.delete();
    vcycles    = 0;
    consec     = 0;
    prev_valid = 0;
  endtask

  typedef struct {
    int kind;
    int vpct;
    int exp_count;
    bit exp_valid;
  } vec_t;

  vec_t         tbl [4];
  logic [N-1:0] exp_alt;
  logic [N-1:0] frm [10];
  logic [N-1:0] fa, fb, fc;

  initial begin
    rst           = 1'b1;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.img_ready = 1'b0;
    m_reset();
    vcycles    = 0;
    consec     = 0;
    prev_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    check_int("init_valid", int'(bus.img_valid), 0);
    check_vec("init_data", bus.img_data, '0);
    rst = 1'b0;

    // Alternating 1,0 frame with ready low.
    do_reset();
    exp_alt = {392{2'b01}};
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, ~i[0], 1'b0);
      if (i == N - 2) check_int("alt_valid_early", int'(bus.img_valid), 0);
    end
    check_int("alt_valid", int'(bus.img_valid), 1);
    check_vec("alt_data", bus.img_data, exp_alt);
    check_int("alt_count", int'(img_count), 1);
    check_int("alt_overrun", int'(overrun), 0);

    // Single-frame vectors with varying bit_valid density.
    tbl[0] = '{kind: 1, vpct: 50,  exp_count: 1, exp_valid: 1'b1};
    tbl[1] = '{kind: 2, vpct: 60,  exp_count: 1, exp_valid: 1'b1};
    tbl[2] = '{kind: 3, vpct: 85,  exp_count: 1, exp_valid: 1'b1};
    tbl[3] = '{kind: 4, vpct: 100, exp_count: 1, exp_valid: 1'b1};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      send_frame(pattern(tbl[t].kind), tbl[t].vpct, N);
      idle(2, 1'b0);
      check_int("tbl_valid", int'(bus.img_valid), int'(tbl[t].exp_valid));
      check_vec("tbl_data", bus.img_data, pattern(tbl[t].kind));
      check_int("tbl_count", int'(img_count), tbl[t].exp_count);
      check_int("tbl_overrun", int'(overrun), 0);
    end

    // Ten back-to-back frames, ready always high.
    do_reset();
    for (int f = 0; f < 10; f++) frm[f] = rand_frame();
    for (int f = 0; f < 10; f++) send_frame(frm[f], 100, 0);
    idle(2, 1'b1);
    check_int("b2b_pulses", vcycles, 10);
    check_int("b2b_long_pulse", consec, 0);
    check_int("b2b_delivered", delivered.size(), 10);
    for (int f = 0; f < 10 && f < delivered.size(); f++)
      check_vec("b2b_data", delivered[f], frm[f]);
    check_int("b2b_count", int'(img_count), 10);
    check_int("b2b_overrun", int'(overrun), 0);

    // Both banks full -> third frame dropped even though ready rises mid-frame.
    do_reset();
    for (int f = 0; f < 4; f++) frm[f] = rand_frame();
    send_frame(frm[0], 100, N);
    send_frame(frm[1], 100, N);
    send_frame(frm[2], 100, 300);
    send_frame(frm[3], 100, 0);
    idle(3, 1'b1);
    check_int("drop_delivered", delivered.size(), 3);
    if (delivered.size() == 3) begin
      check_vec("drop_f0", delivered[0], frm[0]);
      check_vec("drop_f1", delivered[1], frm[1]);
      check_vec("drop_f3", delivered[2], frm[3]);
    end
    check_int("drop_overrun", int'(overrun), 1);
    check_int("drop_count", int'(img_count), 3);

    // Completion into bank 1 in the same cycle bank 0 is accepted.
    do_reset();
    fa = rand_frame();
    fb = rand_frame();
    fc = rand_frame();
    send_frame(fa, 100, N);
    idle(3, 1'b0);
    send_frame(fb, 100, N - 1);
    check_int("sim_valid", int'(bus.img_valid), 1);
    check_vec("sim_data", bus.img_data, fb);
    check_int("sim_delivered", delivered.size(), 1);
    if (delivered.size() == 1) check_vec("sim_first", delivered[0], fa);
    idle(2, 1'b0);
    send_frame(fc, 100, N);
    idle(1, 1'b0);
    check_int("sim_count", int'(img_count), 3);
    check_int("sim_overrun", int'(overrun), 0);
    check_vec("sim_head", bus.img_data, fb);

    // Reset in the middle of a frame while an image is held.
    do_reset();
    fa = rand_frame();
    fb = rand_frame();
    send_frame(fa, 100, N);
    for (int i = 0; i < 400; i++) cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    send_frame(fb, 100, N);
    idle(1, 1'b0);
    check_int("mid_valid", int'(bus.img_valid), 1);
    check_vec("mid_data", bus.img_data, fb);
    check_int("mid_count", int'(img_count), 1);
    check_int("mid_overrun", int'(overrun), 0);

    // Random bit_valid and ready over several frames, model-checked.
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(rand_frame(), 70, -1);
    idle(4, 1'b1);
    check_int("rand_valid_drained", int'(bus.img_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
